// File: rtl/spi_display_cmd.sv
// spi_display_cmd
//   Command decoder between the SPI slave's received-byte stream and the
//   4-digit 7-segment display registers. It parses framed byte commands,
//   updates the digit, colon and LED registers, and returns a one-byte
//   reply for every received byte.
//
// Ports
//   clk        system clock (WF_CLK)
//   reset      synchronous, active-high reset
//   rx_valid   one-cycle strobe, rx_byte holds a received byte
//   rx_byte    received byte
//   cs_active  high while an SPI transaction is open (already synchronized)
//   tx_byte    reply byte for the next SPI exchange, held until next load
//   tx_valid   one-cycle strobe, tx_byte has just been loaded
//   digit0..3  BCD digits, digit0 is the least significant
//   colon      00 colon, 01 decimal point, 11 none
//   led        user LED
//   err_count  saturating count of protocol errors
module spi_display_cmd #(
  parameter logic [7:0] ACK_BASE = 8'hA0,
  parameter logic [7:0] NAK_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       cs_active,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       led,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARG1, ST_ARG2, ST_DRAIN} state_t;

  localparam logic [2:0] CMD_SET_DIGITS  = 3'd1;
  localparam logic [2:0] CMD_SET_COLON   = 3'd2;
  localparam logic [2:0] CMD_SET_LED     = 3'd3;
  localparam logic [2:0] CMD_READ_DIGITS = 3'd4;

  state_t     state_r;
  logic [2:0] cmd_r;
  logic [7:0] shadow_r;
  logic       err_inc_s;
  logic       err_clr_s;

  // Both bytes of a SET_DIGITS payload must be valid packed BCD.
  function automatic logic bcd_ok(input logic [7:0] hi, input logic [7:0] lo);
    return (hi[7:4] <= 4'd9) && (hi[3:0] <= 4'd9) &&
           (lo[7:4] <= 4'd9) && (lo[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] ack(input logic [7:0] cmd);
    return ACK_BASE | {4'h0, cmd[3:0]};
  endfunction

  // Error bookkeeping: unknown command, BCD reject, truncated frame, and clear.
  always_comb begin
    err_inc_s = 1'b0;
    err_clr_s = 1'b0;
    if (!cs_active) begin
      // Leaving ARG1/ARG2 through a dropped chip select is a truncated frame;
      // the FSM returns to IDLE in the same cycle, so this counts once.
      if ((state_r == ST_ARG1) || (state_r == ST_ARG2)) begin
        err_inc_s = 1'b1;
      end else begin
        err_inc_s = 1'b0;
      end
    end else if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_byte > 8'h06) begin
            err_inc_s = 1'b1;
          end else if (rx_byte == 8'h06) begin
            err_clr_s = 1'b1;
          end else begin
            err_inc_s = 1'b0;
          end
        end
        ST_ARG2: begin
          if ((cmd_r == CMD_SET_DIGITS) && !bcd_ok(shadow_r, rx_byte)) begin
            err_inc_s = 1'b1;
          end else begin
            err_inc_s = 1'b0;
          end
        end
        default: begin
          err_inc_s = 1'b0;
        end
      endcase
    end else begin
      err_inc_s = 1'b0;
    end
  end

  // Command FSM with all display registers and the reply path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 3'd0;
      shadow_r  <= 8'h00;
      tx_byte   <= 8'h00;
      tx_valid  <= 1'b0;
      digit0    <= 4'd0;
      digit1    <= 4'd0;
      digit2    <= 4'd0;
      digit3    <= 4'd0;
      colon     <= 2'b00;
      led       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      tx_valid <= 1'b0;

      // Clear wins over a same-cycle error event.
      if (err_clr_s) begin
        err_count <= 8'h00;
      end else if (err_inc_s) begin
        err_count <= sat_inc(err_count);
      end

      if (!cs_active) begin
        // Any byte strobed alongside a dropped chip select is discarded.
        state_r  <= ST_IDLE;
        shadow_r <= 8'h00;
      end else if (rx_valid) begin
        tx_valid <= 1'b1;
        case (state_r)
          ST_IDLE: begin
            cmd_r <= rx_byte[2:0];
            case (rx_byte)
              8'h00, 8'h06: begin
                tx_byte <= ack(rx_byte);
                state_r <= ST_DRAIN;
              end
              8'h05: begin
                tx_byte <= err_count;
                state_r <= ST_DRAIN;
              end
              8'h01, 8'h02, 8'h03, 8'h04: begin
                tx_byte <= ack(rx_byte);
                state_r <= ST_ARG1;
              end
              default: begin
                tx_byte <= NAK_BYTE;
                state_r <= ST_DRAIN;
              end
            endcase
          end
          ST_ARG1: begin
            case (cmd_r)
              CMD_SET_DIGITS: begin
                shadow_r <= rx_byte;
                tx_byte  <= 8'h00;
                state_r  <= ST_ARG2;
              end
              CMD_SET_COLON: begin
                colon   <= rx_byte[1:0];
                tx_byte <= 8'h00;
                state_r <= ST_DRAIN;
              end
              CMD_SET_LED: begin
                led     <= rx_byte[0];
                tx_byte <= 8'h00;
                state_r <= ST_DRAIN;
              end
              CMD_READ_DIGITS: begin
                tx_byte <= {digit3, digit2};
                state_r <= ST_ARG2;
              end
              default: begin
                tx_byte <= 8'h00;
                state_r <= ST_DRAIN;
              end
            endcase
          end
          ST_ARG2: begin
            case (cmd_r)
              CMD_SET_DIGITS: begin
                // All four digits commit together so no partial value is shown.
                if (bcd_ok(shadow_r, rx_byte)) begin
                  digit3  <= shadow_r[7:4];
                  digit2  <= shadow_r[3:0];
                  digit1  <= rx_byte[7:4];
                  digit0  <= rx_byte[3:0];
                  tx_byte <= ack(8'h01);
                end else begin
                  tx_byte <= NAK_BYTE;
                end
                state_r <= ST_DRAIN;
              end
              CMD_READ_DIGITS: begin
                tx_byte <= {digit1, digit0};
                state_r <= ST_DRAIN;
              end
              default: begin
                tx_byte <= 8'h00;
                state_r <= ST_DRAIN;
              end
            endcase
          end
          ST_DRAIN: begin
            tx_byte <= 8'h00;
          end
          default: begin
            tx_byte <= 8'h00;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_display_cmd.sv
// Bench for spi_display_cmd: directed frames from the test plan plus random
// frames, every reply and register checked against a frame-level model.
module tb_spi_display_cmd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cs_active = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] colon;
  logic       led;
  logic [7:0] err_count;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model state
  logic [15:0] m_digits = 16'h0000;
  logic [1:0]  m_colon = 2'b00;
  logic        m_led = 1'b0;
  logic [7:0]  m_err = 8'h00;
  logic [7:0]  m_tx = 8'h00;

  spi_display_cmd dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cs_active(cs_active), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .colon(colon), .led(led), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_digits = 16'h0000;
    m_colon  = 2'b00;
    m_led    = 1'b0;
    m_err    = 8'h00;
    m_tx     = 8'h00;
  endtask

  task automatic err_bump();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  function automatic bit is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Reply and side effects for byte number pos of a frame starting with cmd.
  task automatic model_byte(input int pos, input logic [7:0] cmd, input logic [7:0] a1,
                            input logic [7:0] b, output logic [7:0] rep);
    rep = 8'h00;
    if (pos == 0) begin
      if (cmd <= 8'h06) begin
        rep = (cmd == 8'h05) ? m_err : (8'hA0 | cmd);
        if (cmd == 8'h06) m_err = 8'h00;
      end else begin
        rep = 8'hEE;
        err_bump();
      end
    end else if (cmd == 8'h01 && pos == 2) begin
      if (is_bcd(a1) && is_bcd(b)) begin
        m_digits = {a1, b};
        rep = 8'hA1;
      end else begin
        rep = 8'hEE;
        err_bump();
      end
    end else if (cmd == 8'h02 && pos == 1) begin
      m_colon = b[1:0];
    end else if (cmd == 8'h03 && pos == 1) begin
      m_led = b[0];
    end else if (cmd == 8'h04 && pos == 1) begin
      rep = m_digits[15:8];
    end else if (cmd == 8'h04 && pos == 2) begin
      rep = m_digits[7:0];
    end
    m_tx = rep;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_digits"}, {digit3, digit2, digit1, digit0}, m_digits);
    check_eq({tag, "_colon"}, colon, m_colon);
    check_eq({tag, "_led"}, led, m_led);
    check_eq({tag, "_err"}, err_count, m_err);
  endtask

  task automatic send_byte(input int pos, input logic [7:0] cmd, input logic [7:0] a1,
                           input logic [7:0] b);
    logic [7:0] rep;
    model_byte(pos, cmd, a1, b, rep);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
    check_eq("tx_valid", tx_valid, 32'd1);
    check_eq("tx_byte", tx_byte, rep);
    check_regs("byte");
  endtask

  // One frame of n bytes; drop_with_byte strobes a byte together with cs falling.
  task automatic run_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input bit drop_with_byte, input bit gaps);
    logic [7:0] fb [4];
    int needs;
    fb = '{b0, b1, b2, b3};
    cs_active = 1'b1;
    step();
    check_eq("idle_tx_valid", tx_valid, 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(i, fb[0], fb[1], fb[i]);
      if (gaps && $urandom_range(0, 1) == 1) begin
        step();
        check_eq("gap_tx_valid", tx_valid, 32'd0);
        check_eq("gap_tx_hold", tx_byte, m_tx);
      end
    end
    needs = (b0 == 8'h01 || b0 == 8'h04) ? 3 : ((b0 == 8'h02 || b0 == 8'h03) ? 2 : 1);
    if (n < needs) err_bump();
    cs_active = 1'b0;
    if (drop_with_byte) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
    end
    step();
    rx_valid = 1'b0;
    check_eq("drop_tx_valid", tx_valid, 32'd0);
    check_eq("drop_tx_hold", tx_byte, m_tx);
    check_regs("drop");
  endtask

  initial begin
    logic [7:0] rb [4];
    int n;
    int sel;

    step();
    step();
    reset = 1'b0;
    check_eq("rst_tx_byte", tx_byte, 32'h00);
    check_eq("rst_tx_valid", tx_valid, 32'd0);
    check_regs("rst");

    // SET_DIGITS commit, then BCD reject, then CLR_ERR
    run_frame(3, 8'h01, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
    check_eq("digits_1234", {digit3, digit2, digit1, digit0}, 32'h1234);
    run_frame(3, 8'h01, 8'h1A, 8'h34, 8'h00, 1'b0, 1'b0);
    check_eq("bcd_reject_err", err_count, 32'h01);
    run_frame(1, 8'h06, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("clr_err", err_count, 32'h00);

    // Truncated SET_DIGITS, then SET_LED
    run_frame(2, 8'h01, 8'h56, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("trunc_err", err_count, 32'h01);
    run_frame(2, 8'h03, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("led_on", led, 32'd1);

    // READ_DIGITS back-to-back after setting 9876
    run_frame(3, 8'h01, 8'h98, 8'h76, 8'h00, 1'b0, 1'b0);
    run_frame(3, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // rx_valid coincident with cs falling while in ARG2
    run_frame(2, 8'h01, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("coincident_digits", {digit3, digit2, digit1, digit0}, 32'h9876);

    // Saturation
    for (int i = 0; i < 300; i++) run_frame(1, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("err_saturated", err_count, 32'hFF);
    run_frame(1, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("read_err_reply", tx_byte, 32'hFF);

    // Reset during ARG1 of SET_COLON; next byte with cs still high is a command
    cs_active = 1'b1;
    step();
    send_byte(0, 8'h02, 8'h00, 8'h02);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check_eq("midrst_tx_byte", tx_byte, 32'h00);
    check_eq("midrst_tx_valid", tx_valid, 32'd0);
    check_regs("midrst");
    send_byte(0, 8'h03, 8'h00, 8'h03);
    send_byte(1, 8'h03, 8'h00, 8'h01);
    check_eq("postrst_led", led, 32'd1);
    cs_active = 1'b0;
    step();
    check_regs("postrst");

    // Random frames
    for (int f = 0; f < 200; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) rb[0] = 8'(sel);
      else if (sel == 7) rb[0] = 8'($urandom);
      else rb[0] = (sel == 8) ? 8'h01 : 8'h04;
      for (int k = 1; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1)
          rb[k] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        else
          rb[k] = 8'($urandom);
      end
      n = $urandom_range(1, 4);
      run_frame(n, rb[0], rb[1], rb[2], rb[3], ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/spi_display_cmd.md
# spi_display_cmd

Command decoder between the SPI slave's received-byte stream and the 4-digit 7-segment interface. It parses framed byte commands and updates the digit, colon and LED registers that drive the display scanner. Each received byte gets a one-byte reply, which the block loads into the SPI slave's transmit path. Everything runs on the system clock; SPI-side strobes arrive already synchronized.

## Interface
- Parameters:
- ACK_BASE, 8'hA0: reply base for an accepted command byte; reply = ACK_BASE | cmd[3:0].
- NAK_BYTE, 8'hEE: reply to an unknown command, or to a SET_DIGITS that fails the BCD check.
- Ports:
- clk  in  1  system clock (WF_CLK).
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte.
- cs_active  in  1  high while an SPI transaction is open (synchronized, active-high).
- tx_byte  out  8  reply byte for the next SPI exchange.
- tx_valid  out  1  one-cycle strobe: tx_byte is loaded.
- digit0..digit3  out  4 each  BCD digits (digit0 is the LSD).
- colon  out  2  00 colon, 01 decimal point, 11 none.
- led  out  1  user LED.
- err_count  out  8  saturating count of protocol errors.

## Operation
- A frame is the bytes received while cs_active is high. The first byte is the command; any following bytes are its arguments.
- Commands:
  - 0x00 NOP.
  - 0x01 SET_DIGITS: arg1 = {d3,d2}, arg2 = {d1,d0}.
  - 0x02 SET_COLON: arg bits [1:0].
  - 0x03 SET_LED: arg bit 0.
  - 0x04 READ_DIGITS.
  - 0x05 READ_ERR.
  - 0x06 CLR_ERR.
- FSM states:
  - IDLE (awaiting command). A command byte moves to ARG1 for 0x01/0x02/0x03/0x04. It moves to DRAIN for 0x00/0x05/0x06, after executing 0x06. It moves to DRAIN for an unknown command.
  - ARG1. 0x01 stores arg1 in a shadow register and moves to ARG2. 0x02/0x03 commit the value and move to DRAIN. 0x04 moves to ARG2.
  - ARG2. 0x01 commits if all four nibbles are ≤ 9, otherwise rejects. 0x04 moves to DRAIN.
  - DRAIN. Further bytes are ignored; each gets reply 0x00.
- SET_DIGITS commits all four digits atomically in one cycle; a partial update is never visible.
- Reply generation (tx_byte for each rx byte):
  - Command byte: ACK_BASE|cmd[3:0] for a known command, NAK_BYTE for an unknown one.
  - For READ_DIGITS, the reply to arg byte 1 is {digit3,digit2} and to arg byte 2 is {digit1,digit0}.
  - For READ_ERR, the reply to the command byte is err_count instead of an ack.
  - Reply to the SET_DIGITS arg2 byte: ACK_BASE|4'h1 on commit, NAK_BYTE on BCD reject.
  - All other argument bytes get reply 0x00.
- err_count increments by 1, saturating at 8'hFF, on any of:
  - an unknown command;
  - a BCD reject;
  - cs_active falling while in ARG1 or ARG2 (truncated frame).
- CLR_ERR sets err_count to 0. If an error event occurs in the same cycle, the clear wins.
- cs_active low, in any state: return to IDLE and discard the shadow register. An rx_valid arriving in the same cycle as cs_active low is discarded: no reply, no state change.
- rx_valid while cs_active is high and the FSM is in IDLE always starts a new command.

## Timing
- rx_valid at cycle N: tx_valid is high for exactly cycle N+1, with tx_byte valid from N+1 and held until the next load.
- Register commits (digits, colon, led, err_count) are visible at N+1 for the byte at N.
- Back-to-back rx_valid on consecutive cycles must be supported; each byte produces its own tx_valid.
- Reset values: digits 0, colon 2'b00, led 0, err_count 0, tx_byte 8'h00, tx_valid 0, FSM in IDLE.
- Reset asserted mid-frame: all of the above apply on the next clock edge. Frame resumption requires a new cs_active rising edge; bytes received before that edge are treated as a new command.

## Test plan
- Frame 01,12,34: digits become d3=1, d2=2, d1=3, d0=4 in one cycle at arg2+1. Replies A1,00,A1.
- Frame 01,1A,34: digits unchanged, arg2 reply EE, err_count 0→1. Then frame 06: err_count becomes 0, reply A6.
- Frame 01,56 with cs_active dropped before arg2: digits unchanged, err_count +1. The next frame 03,01 sets led=1.
- Frame 04,00,00 after digits were set to 9876: replies A4,98,76. The tx_valid strobes are exactly one cycle after each rx_valid.
- 300 unknown-command frames (0x7F): err_count saturates at FF. Each reply is EE. Frame 05 then replies FF.
- rx_valid coincident with cs_active falling: no tx_valid and no state change. Reset pulsed during ARG1 of SET_COLON: colon=00, FSM in IDLE, tx_byte=00.
